// File: rtl/ir_car_drive.sv
// Drive controller for the IR car: turns one-hot remote keys into a drive FSM with speed levels,
// timed pivot turns, a no-key watchdog, direction-change dead time and per-motor PWM.
module ir_car_drive #(
    parameter int unsigned PWM_PERIOD = 1000,
    parameter int unsigned PWM_STEP   = 100,
    parameter int unsigned DEF_SPEED  = 5,
    parameter int unsigned TURN_TICKS = 400000,
    parameter int unsigned TIMEOUT    = 3000000,
    parameter int unsigned DEAD_TICKS = 1000
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [16:0] key,
    output logic        motor_l_pwm,
    output logic        motor_r_pwm,
    output logic        motor_l_dir,
    output logic        motor_r_dir,
    output logic [2:0]  state,
    output logic [3:0]  speed,
    output logic        wd_en,
    output logic        key_evt
);

    localparam int unsigned CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int unsigned TW = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_TICKS - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS);

    typedef enum logic [2:0] {
        StStop  = 3'd0,
        StFwd   = 3'd1,
        StRev   = 3'd2,
        StTurnL = 3'd3,
        StTurnR = 3'd4
    } drive_state_e;

    drive_state_e  state_q, state_d, ret_q, ret_d;
    logic [16:0]   key_q;
    logic [3:0]    speed_q, speed_d;
    logic          wd_en_q, wd_en_d;
    logic [TW-1:0] turn_cnt_q, turn_cnt_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic          dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic          pwm_q, pwm_d;
    logic          key_evt_q;

    logic          key_one, evt, moving, turning;
    logic [3:0]    digit;
    logic [31:0]   duty;

    always_comb begin
        key_one = (key != '0) && ((key & (key - 17'd1)) == '0);
        evt     = key_one && (key_q == '0);
        moving  = (state_q == StFwd) || (state_q == StRev);
        turning = (state_q == StTurnL) || (state_q == StTurnR);
        // Bit 16 is digit 0, bits 15..7 are digits 1..9.
        digit   = '0;
        for (int i = 7; i <= 16; i++) begin
            if (key[i]) digit = 4'(16 - i);
        end
    end

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        wd_en_d    = wd_en_q;
        ret_d      = ret_q;
        turn_cnt_d = turn_cnt_q;

        if (evt || !moving) begin
            wd_cnt_d = '0;
        end else if (wd_en_q) begin
            wd_cnt_d = wd_cnt_q + WW'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end

        if (evt) begin
            if (|key[16:7]) begin
                speed_d = digit;
            end else begin
                unique case (1'b1)
                    key[6]: state_d = StStop;
                    key[5]: state_d = StFwd;
                    key[4]: state_d = StRev;
                    key[3], key[2]: begin
                        state_d    = key[3] ? StTurnL : StTurnR;
                        turn_cnt_d = TURN_LOAD;
                        if (!turning) ret_d = state_q;
                    end
                    key[1]: begin
                        state_d = StStop;
                        speed_d = '0;
                    end
                    key[0]: wd_en_d = !wd_en_q;
                    default: ;
                endcase
            end
        end else if (turning) begin
            if (turn_cnt_q == '0) begin
                state_d = ret_q;
            end else begin
                turn_cnt_d = turn_cnt_q - TW'(1);
            end
        end else if (moving && wd_en_q && (wd_cnt_q >= WD_LAST)) begin
            state_d = StStop;
        end

        // STOP keeps the last direction so stopping never triggers dead time.
        dir_l_d = dir_l_q;
        dir_r_d = dir_r_q;
        case (state_d)
            StFwd:   {dir_l_d, dir_r_d} = 2'b11;
            StRev:   {dir_l_d, dir_r_d} = 2'b00;
            StTurnL: {dir_l_d, dir_r_d} = 2'b01;
            StTurnR: {dir_l_d, dir_r_d} = 2'b10;
            default: ;
        endcase

        if ({dir_l_d, dir_r_d} != {dir_l_q, dir_r_q}) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end else begin
            dead_d = dead_q;
        end

        pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + CW'(1);
        duty      = 32'(speed_q) * PWM_STEP;
        pwm_d     = (32'(pwm_cnt_q) < duty) && (state_q != StStop) && (dead_q == '0);
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            key_q      <= '0;
            state_q    <= StStop;
            ret_q      <= StStop;
            speed_q    <= 4'(DEF_SPEED);
            wd_en_q    <= 1'b1;
            turn_cnt_q <= '0;
            wd_cnt_q   <= '0;
            dead_q     <= '0;
            pwm_cnt_q  <= '0;
            dir_l_q    <= 1'b1;
            dir_r_q    <= 1'b1;
            pwm_q      <= 1'b0;
            key_evt_q  <= 1'b0;
        end else begin
            key_q      <= key;
            state_q    <= state_d;
            ret_q      <= ret_d;
            speed_q    <= speed_d;
            wd_en_q    <= wd_en_d;
            turn_cnt_q <= turn_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            dead_q     <= dead_d;
            pwm_cnt_q  <= pwm_cnt_d;
            dir_l_q    <= dir_l_d;
            dir_r_q    <= dir_r_d;
            pwm_q      <= pwm_d;
            key_evt_q  <= evt;
        end
    end

    assign state       = state_q;
    assign speed       = speed_q;
    assign wd_en       = wd_en_q;
    assign key_evt     = key_evt_q;
    assign motor_l_dir = dir_l_q;
    assign motor_r_dir = dir_r_q;
    assign motor_l_pwm = pwm_q;
    assign motor_r_pwm = pwm_q;

endmodule

// File: tb/tb_ir_car_drive.sv
// Bench for ir_car_drive: key events are checked by a scoreboard monitor, timing and PWM
// behaviour by directed checks in the stimulus thread.
module tb_ir_car_drive;

    logic        clk_d = 1'b0;
    logic        rst;
    logic [16:0] key;
    logic        motor_l_pwm, motor_r_pwm, motor_l_dir, motor_r_dir;
    logic [2:0]  state;
    logic [3:0]  speed;
    logic        wd_en, key_evt;

    always #5 clk_d = ~clk_d;

    ir_car_drive #(
        .PWM_PERIOD(10),
        .PWM_STEP  (1),
        .DEF_SPEED (5),
        .TURN_TICKS(50),
        .TIMEOUT   (200),
        .DEAD_TICKS(4)
    ) dut (
        .clk_d      (clk_d),
        .rst        (rst),
        .key        (key),
        .motor_l_pwm(motor_l_pwm),
        .motor_r_pwm(motor_r_pwm),
        .motor_l_dir(motor_l_dir),
        .motor_r_dir(motor_r_dir),
        .state      (state),
        .speed      (speed),
        .wd_en      (wd_en),
        .key_evt    (key_evt)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sp;
        logic       wd;
        logic       dl;
        logic       dr;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_d);
        #1;
    endtask

    // Queue the expected post-event outputs, then pulse the key for one cycle.
    task automatic press(input logic [16:0] k, input logic [2:0] st, input logic [3:0] sp,
                         input logic wd, input logic dl, input logic dr);
        sb_q.push_back({st, sp, wd, dl, dr});
        key = k;
        tick();
        key = '0;
        tick();
    endtask

    task automatic count_pwm(input int n, output int hl, output int hr);
        hl = 0;
        hr = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            hl += int'(motor_l_pwm);
            hr += int'(motor_r_pwm);
        end
    endtask

    always @(negedge clk_d) begin
        if (key_evt) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_key_evt: got event with state %0d speed %0d, required none",
                         state, speed);
            end else begin
                mon_e = sb_q.pop_front();
                check("evt_state", 32'(state), 32'(mon_e.st));
                check("evt_speed", 32'(speed), 32'(mon_e.sp));
                check("evt_wd_en", 32'(wd_en), 32'(mon_e.wd));
                check("evt_dir_l", 32'(motor_l_dir), 32'(mon_e.dl));
                check("evt_dir_r", 32'(motor_r_dir), 32'(mon_e.dr));
            end
        end
    end

    initial begin
        int hl, hr, evts, dead_hi, turn_hi;
        rst = 1'b1;
        key = '0;
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_speed", 32'(speed), 5);
        check("rst_wd_en", 32'(wd_en), 1);
        check("rst_dirs", 32'({motor_l_dir, motor_r_dir}), 3);
        check("rst_pwms", 32'({motor_l_pwm, motor_r_pwm}), 0);
        check("rst_key_evt", 32'(key_evt), 0);
        rst = 1'b0;
        tick();

        // Up held for 30 cycles: one event, no dead time (dirs already forward).
        sb_q.push_back({3'd1, 4'd5, 1'b1, 1'b1, 1'b1});
        key = 17'h00020;
        tick();
        check("up_first_pwm", 32'(motor_l_pwm), 0);
        evts = int'(key_evt);
        repeat (29) begin
            tick();
            evts += int'(key_evt);
        end
        key = '0;
        tick();
        evts += int'(key_evt);
        check("up_held_one_evt", 32'(evts), 1);
        count_pwm(20, hl, hr);
        check("duty5_l", 32'(hl), 10);
        check("duty5_r", 32'(hr), 10);

        press(17'h00100, 3'd1, 4'd8, 1'b1, 1'b1, 1'b1);
        count_pwm(20, hl, hr);
        check("duty8_l", 32'(hl), 16);
        check("duty8_r", 32'(hr), 16);
        press(17'h10000, 3'd1, 4'd0, 1'b1, 1'b1, 1'b1);
        count_pwm(20, hl, hr);
        check("duty0_l", 32'(hl), 0);
        check("duty0_state", 32'(state), 1);
        press(17'h00800, 3'd1, 4'd5, 1'b1, 1'b1, 1'b1);

        // Timed left turn from FWD; i counts edges after the turn event.
        press(17'h00008, 3'd3, 4'd5, 1'b1, 1'b0, 1'b1);
        dead_hi = 0;
        turn_hi = 0;
        hl = 0;
        for (int i = 1; i <= 54; i++) begin
            if (i > 1) tick();
            if (i <= 4) dead_hi += int'(motor_l_pwm) + int'(motor_r_pwm);
            if (i >= 5 && i <= 44) turn_hi += int'(motor_l_pwm);
            if (i == 49) check("turn_still_left", 32'(state), 3);
            if (i == 50) begin
                check("turn_return_fwd", 32'(state), 1);
                check("turn_return_dirs", 32'({motor_l_dir, motor_r_dir}), 3);
            end
            if (i >= 51) hl += int'(motor_l_pwm) + int'(motor_r_pwm);
        end
        check("turn_dead_pwm", 32'(dead_hi), 0);
        check("turn_duty", 32'(turn_hi), 20);
        check("return_dead_pwm", 32'(hl), 0);

        // Watchdog from REV.
        press(17'h00010, 3'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 200; i++) begin
            tick();
            if (i == 199) check("wd_not_yet", 32'(state), 2);
            if (i == 200) check("wd_timeout", 32'(state), 0);
        end
        check("stop_holds_dirs", 32'({motor_l_dir, motor_r_dir}), 0);

        press(17'h00001, 3'd0, 4'd5, 1'b0, 1'b0, 1'b0);
        press(17'h00010, 3'd2, 4'd5, 1'b0, 1'b0, 1'b0);
        repeat (1000) tick();
        check("wd_disabled", 32'(state), 2);

        // Re-enable, then land a down event on the very edge the watchdog expires.
        press(17'h00001, 3'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 199; i++) tick();
        sb_q.push_back({3'd2, 4'd5, 1'b1, 1'b0, 1'b0});
        key = 17'h00010;
        tick();
        key = '0;
        check("evt_beats_timeout", 32'(state), 2);
        tick();
        check("evt_beats_timeout_after", 32'(state), 2);

        press(17'h00004, 3'd4, 4'd5, 1'b1, 1'b1, 1'b0);
        press(17'h00002, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("estop_state", 32'(state), 0);
        check("estop_speed", 32'(speed), 0);

        key = 17'h00030;
        repeat (3) tick();
        key = '0;
        tick();
        check("invalid_state", 32'(state), 0);
        check("invalid_speed", 32'(speed), 0);

        sb_q.push_back({3'd0, 4'd0, 1'b1, 1'b1, 1'b0});
        key = 17'h00040;
        evts = 0;
        repeat (100) begin
            tick();
            evts += int'(key_evt);
        end
        key = '0;
        tick();
        check("ok_held_one_evt", 32'(evts), 1);

        // Reset in the middle of a turn and its dead time.
        press(17'h00008, 3'd3, 4'd0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(state), 0);
        check("midrst_speed", 32'(speed), 5);
        check("midrst_wd_en", 32'(wd_en), 1);
        check("midrst_dirs", 32'({motor_l_dir, motor_r_dir}), 3);
        check("midrst_pwms", 32'({motor_l_pwm, motor_r_pwm}), 0);
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_state", 32'(state), 0);

        check("sb_drained", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
